updown_counter_mod: RTL and testbench

Parametrised loadable up/down counter with a run-time programmable modulus, configurable step size, and selectable wrap or saturate behaviour at the boundaries. It reports events through a terminal-count pulse, a sticky overflow flag, and boundary status flags. It is the general-purpose counter for timers, dividers and address sequencers, and replaces the fixed 4-bit counter in new designs.

---
 rtl/updown_counter_mod.sv | 126 ++++++++++++
 tb/tb_updown_counter_mod.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// Loadable up/down counter with a run-time modulus (limit+1), a fixed step,
// wrap or saturate at the bounds, a terminal-count pulse and a sticky overflow flag.
module updown_counter_mod #(
    parameter int WIDTH   = 8,
    parameter int STEP    = 1,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             upordown,
    input  logic             load,
    input  logic [WIDTH-1:0] num2load,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat_mode,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RST_VAL);
    localparam logic [WIDTH:0]   ONE_X  = (WIDTH + 1)'(1);

    // One extra bit so that count+STEP and limit+1 never alias modulo 2^WIDTH.
    logic [WIDTH:0] count_x;
    logic [WIDTH:0] limit_x;
    logic [WIDTH:0] mod_x;
    logic [WIDTH:0] sum_x;
    logic [WIDTH:0] up_wrap_x;
    logic [WIDTH:0] dn_wrap_x;
    logic           above;
    logic           step_fits;

    assign count_x   = {1'b0, count};
    assign limit_x   = {1'b0, limit};
    assign mod_x     = limit_x + ONE_X;
    assign sum_x     = count_x + STEP_X;
    assign up_wrap_x = sum_x - mod_x;
    assign dn_wrap_x = count_x + mod_x - STEP_X;
    assign above     = (count_x > limit_x);
    assign step_fits = (STEP_X <= mod_x);

    // Wrapped results are always below limit+1, so their top bit is always zero.
    logic unused_bits;
    assign unused_bits = &{1'b0, up_wrap_x[WIDTH], dn_wrap_x[WIDTH]};

    logic [WIDTH-1:0] up_next;
    logic             up_evt;
    logic [WIDTH-1:0] dn_next;
    logic             dn_evt;

    always_comb begin
        up_next = limit;
        up_evt  = 1'b1;
        if (above) begin
            up_next = sat_mode ? limit : '0;
            up_evt  = 1'b1;
        end else if (sum_x <= limit_x) begin
            up_next = sum_x[WIDTH-1:0];
            up_evt  = 1'b0;
        end else if (!sat_mode && step_fits) begin
            up_next = up_wrap_x[WIDTH-1:0];
            up_evt  = 1'b1;
        end
    end

    // A stale count above a freshly lowered limit is pulled back silently on a down step.
    always_comb begin
        dn_next = '0;
        dn_evt  = 1'b1;
        if (above) begin
            dn_next = limit;
            dn_evt  = 1'b0;
        end else if (count_x >= STEP_X) begin
            dn_next = count - STEP_X[WIDTH-1:0];
            dn_evt  = 1'b0;
        end else if (!sat_mode && step_fits) begin
            dn_next = dn_wrap_x[WIDTH-1:0];
            dn_evt  = 1'b1;
        end
    end

    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] next_count;
    logic             next_evt;

    assign load_val = (num2load > limit) ? limit : num2load;

    always_comb begin
        next_count = count;
        next_evt   = 1'b0;
        if (clear) begin
            next_count = RST_V;
        end else if (load) begin
            next_count = load_val;
        end else if (enable) begin
            next_count = upordown ? up_next : dn_next;
            next_evt   = upordown ? up_evt  : dn_evt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_V;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= next_count;
            tc    <= next_evt;
            if (next_evt) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign at_max = (count == limit);
    assign at_min = (count == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: a STEP=1 and a STEP=3 instance share
// stimulus; a negedge monitor checks the selected instance against queued expectations.
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, up = 1'b0, ld = 1'b0, clr = 1'b0, sat = 1'b0, oc = 1'b0;
    logic [7:0] n2l = '0, lim = '0;

    logic [7:0] c1, c3;
    logic       tc1, ovf1, mx1, mn1;
    logic       tc3, ovf3, mx3, mn3;

    int tests = 0;
    int fails = 0;

    // Entry: {sel, count[7:0], tc, ovf, at_max, at_min}; sel=1 picks the STEP=3 instance.
    logic [12:0] exp_q[$];
    string       name_q[$];

    updown_counter_mod #(.WIDTH(8), .STEP(1), .RST_VAL(0)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en), .upordown(up), .load(ld),
        .num2load(n2l), .clear(clr), .limit(lim), .sat_mode(sat), .ovf_clr(oc),
        .count(c1), .tc(tc1), .ovf(ovf1), .at_max(mx1), .at_min(mn1)
    );

    updown_counter_mod #(.WIDTH(8), .STEP(3), .RST_VAL(0)) u3 (
        .clk(clk), .rst_n(rst_n), .enable(en), .upordown(up), .load(ld),
        .num2load(n2l), .clear(clr), .limit(lim), .sat_mode(sat), .ovf_clr(oc),
        .count(c3), .tc(tc3), .ovf(ovf3), .at_max(mx3), .at_min(mn3)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: act count=%0d tc=%b ovf=%b max=%b min=%b, req count=%0d tc=%b ovf=%b max=%b min=%b",
                     nm, act[11:4], act[3], act[2], act[1], act[0],
                     exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: every negedge, the oldest expectation belongs to the edge just taken.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            automatic logic [12:0] e  = exp_q.pop_front();
            automatic string       nm = name_q.pop_front();
            automatic logic [11:0] act;
            act = e[12] ? {c3, tc3, ovf3, mx3, mn3} : {c1, tc1, ovf1, mx1, mn1};
            check(nm, act, e[11:0]);
        end
    end

    // Driver: apply one cycle of inputs and queue the response expected after the next edge.
    task automatic drive(input string nm, input bit sel,
                         input bit e_en, input bit e_up, input bit e_ld, input logic [7:0] e_n2l,
                         input bit e_clr, input logic [7:0] e_lim, input bit e_sat, input bit e_oc,
                         input logic [7:0] ec, input bit etc, input bit eovf);
        @(negedge clk);
        #1;
        en = e_en; up = e_up; ld = e_ld; n2l = e_n2l;
        clr = e_clr; lim = e_lim; sat = e_sat; oc = e_oc;
        exp_q.push_back({sel, ec, etc, eovf, ec == e_lim, ec == 8'd0});
        name_q.push_back(nm);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 8) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: act pending=%0d req pending=0", exp_q.size());
        end
    endtask

    logic [7:0] t1_cnt[12];

    initial begin
        t1_cnt = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0, 8'd1, 8'd2};

        // Reset
        #12;
        check("reset_u1", {c1, tc1, ovf1, 2'b11}, {8'd0, 1'b0, 1'b0, 2'b11});
        check("reset_u3", {c3, tc3, ovf3, 2'b11}, {8'd0, 1'b0, 1'b0, 2'b11});
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Wrap up through limit 9
        for (int i = 0; i < 12; i++)
            drive($sformatf("wrap_up_%0d", i), 0, 1, 1, 0, 0, 0, 9, 0, 0,
                  t1_cnt[i], i == 9, i >= 9);

        // Wrap down from 0, ovf set/clear race, ovf clear alone
        drive("clear_to_0",    0, 0, 0, 0, 0, 1, 9, 0, 0, 8'd0, 0, 1);
        drive("down_wrap_9",   0, 1, 0, 0, 0, 0, 9, 0, 0, 8'd9, 1, 1);
        drive("down_8",        0, 1, 0, 0, 0, 0, 9, 0, 0, 8'd8, 0, 1);
        drive("load_9",        0, 0, 0, 1, 9, 0, 9, 0, 0, 8'd9, 0, 1);
        drive("set_beats_clr", 0, 1, 1, 0, 0, 0, 9, 0, 1, 8'd0, 1, 1);
        drive("ovf_clr_only",  0, 0, 0, 0, 0, 0, 9, 0, 1, 8'd0, 0, 0);

        // STEP=3, limit 10
        drive("s3_load_8",     1, 0, 0, 1, 8, 0, 10, 0, 1, 8'd8,  0, 0);
        drive("s3_up_wrap_0",  1, 1, 1, 0, 0, 0, 10, 0, 0, 8'd0,  1, 1);
        drive("s3_load_1",     1, 0, 0, 1, 1, 0, 10, 0, 0, 8'd1,  0, 1);
        drive("s3_dn_wrap_9",  1, 1, 0, 0, 0, 0, 10, 0, 0, 8'd9,  1, 1);
        drive("s3_sat_load_9", 1, 0, 0, 1, 9, 0, 10, 1, 0, 8'd9,  0, 1);
        drive("s3_sat_up_a",   1, 1, 1, 0, 0, 0, 10, 1, 0, 8'd10, 1, 1);
        drive("s3_sat_up_b",   1, 1, 1, 0, 0, 0, 10, 1, 0, 8'd10, 1, 1);
        drive("s3_sat_up_c",   1, 1, 1, 0, 0, 0, 10, 1, 0, 8'd10, 1, 1);
        drive("s3_sat_load_2", 1, 0, 0, 1, 2, 0, 10, 1, 0, 8'd2,  0, 1);
        drive("s3_sat_dn_a",   1, 1, 0, 0, 0, 0, 10, 1, 0, 8'd0,  1, 1);
        drive("s3_sat_dn_b",   1, 1, 0, 0, 0, 0, 10, 1, 0, 8'd0,  1, 1);
        // Step larger than modulus: wrap mode still clamps to the bound
        drive("s3_lim1_load",  1, 0, 0, 1, 1, 0, 1, 0, 1, 8'd1,  0, 0);
        drive("s3_big_up",     1, 1, 1, 0, 0, 0, 1, 0, 0, 8'd1,  1, 1);
        drive("s3_big_dn",     1, 1, 0, 0, 0, 0, 1, 0, 0, 8'd0,  1, 1);

        // limit = 0
        drive("lim0_load",     0, 0, 0, 1, 200, 0, 0, 0, 1, 8'd0, 0, 0);
        drive("lim0_up",       0, 1, 1, 0, 0,   0, 0, 0, 0, 8'd0, 1, 1);
        drive("lim0_dn",       0, 1, 0, 0, 0,   0, 0, 0, 0, 8'd0, 1, 1);

        // Priority and load clamp
        drive("load_7",        0, 0, 0, 1, 7,   0, 50, 0, 1, 8'd7,  0, 0);
        drive("clr_beats_all", 0, 1, 1, 1, 5,   1, 50, 0, 0, 8'd0,  0, 0);
        drive("load_clamp_50", 0, 1, 1, 1, 200, 0, 50, 0, 0, 8'd50, 0, 0);
        drive("load_beats_en", 0, 1, 1, 1, 5,   0, 50, 0, 0, 8'd5,  0, 0);

        // Limit lowered under the count
        drive("low_load_40a",  0, 0, 0, 1, 40, 0, 50, 0, 0, 8'd40, 0, 0);
        drive("low_up_wrap",   0, 1, 1, 0, 0,  0, 20, 0, 0, 8'd0,  1, 1);
        drive("low_load_40b",  0, 0, 0, 1, 40, 0, 50, 0, 1, 8'd40, 0, 0);
        drive("low_dn_clamp",  0, 1, 0, 0, 0,  0, 20, 0, 0, 8'd20, 0, 0);
        drive("low_load_40c",  0, 0, 0, 1, 40, 0, 50, 0, 0, 8'd40, 0, 0);
        drive("low_up_sat",    0, 1, 1, 0, 0,  0, 20, 1, 0, 8'd20, 1, 1);

        // Asynchronous reset mid-cycle while tc and ovf are high
        drive("pre_rst_load",  0, 0, 0, 1, 49, 0, 50, 1, 1, 8'd49, 0, 0);
        drive("pre_rst_up",    0, 1, 1, 0, 0,  0, 50, 1, 0, 8'd50, 0, 0);
        drive("pre_rst_sat",   0, 1, 1, 0, 0,  0, 50, 1, 0, 8'd50, 1, 1);
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {c1, tc1, ovf1, mx1, mn1}, {8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        check("rst_held", {c1, tc1, ovf1, mx1, mn1}, {8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        en = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive("post_rst_1",    0, 1, 1, 0, 0, 0, 50, 0, 0, 8'd1, 0, 0);
        drive("post_rst_2",    0, 1, 1, 0, 0, 0, 50, 0, 0, 8'd2, 0, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
